// File: rtl/sbox_share_arb.sv
// sbox_share_arb: time-shares one 16-lane S-box array between the round datapath and key expansion
module sbox_share_arb #(
    parameter int SB_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rnd_req,
    input  logic [127:0] rnd_data,
    output logic         rnd_gnt,
    output logic         rnd_vld,
    output logic [127:0] rnd_res,
    input  logic         key_req,
    input  logic [31:0]  key_word,
    output logic         key_gnt,
    output logic         key_vld,
    output logic [31:0]  key_res,
    input  logic         flush,
    output logic [127:0] sb_in,
    input  logic [127:0] sb_out,
    output logic         busy
);
    // last_q = 1 means key expansion owned the most recent issue
    logic            last_q, last_d;
    logic [127:0]    sb_in_q, sb_in_d, rnd_res_q, rnd_res_d;
    logic [31:0]     key_res_q, key_res_d;
    logic            rnd_vld_q, rnd_vld_d, key_vld_q, key_vld_d;
    // tag pipeline: valid bits and owner bits (1 = key), entry SB_LAT lines up with sb_out
    logic [SB_LAT:0] tv_q, tv_d, to_q, to_d;
    logic            issue, exit_v;

    assign rnd_gnt = !flush && rnd_req && (!key_req || last_q);
    assign key_gnt = !flush && key_req && (!rnd_req || !last_q);
    assign issue   = rnd_gnt || key_gnt;
    assign exit_v  = tv_q[SB_LAT] && !flush;
    assign busy    = |tv_q;
    assign sb_in   = sb_in_q;
    assign rnd_res = rnd_res_q;
    assign key_res = key_res_q;
    assign rnd_vld = rnd_vld_q;
    assign key_vld = key_vld_q;

    // next state: record issues, shift tags, capture exiting results by owner
    always_comb begin
        last_d    = issue ? key_gnt : last_q;
        sb_in_d   = key_gnt ? {96'h0, key_word} : rnd_gnt ? rnd_data : sb_in_q;
        tv_d      = flush ? '0 : {tv_q[SB_LAT-1:0], issue};
        to_d      = {to_q[SB_LAT-1:0], key_gnt};
        rnd_vld_d = exit_v && !to_q[SB_LAT];
        key_vld_d = exit_v && to_q[SB_LAT];
        rnd_res_d = rnd_vld_d ? sb_out : rnd_res_q;
        key_res_d = key_vld_d ? sb_out[31:0] : key_res_q;
    end

    // state registers; reset drops every in-flight tag at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b1;
            sb_in_q   <= '0;
            rnd_res_q <= '0;
            key_res_q <= '0;
            rnd_vld_q <= 1'b0;
            key_vld_q <= 1'b0;
            tv_q      <= '0;
            to_q      <= '0;
        end else begin
            last_q    <= last_d;
            sb_in_q   <= sb_in_d;
            rnd_res_q <= rnd_res_d;
            key_res_q <= key_res_d;
            rnd_vld_q <= rnd_vld_d;
            key_vld_q <= key_vld_d;
            tv_q      <= tv_d;
            to_q      <= to_d;
        end
    end
endmodule

// File: tb/tb_sbox_share_arb.sv
// tb_sbox_share_arb: scoreboard bench for the shared S-box arbiter with a 1-cycle S-box array model
module tb_sbox_share_arb;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         rnd_req = 1'b0, key_req = 1'b0, flush = 1'b0;
    logic [127:0] rnd_data = '0;
    logic [31:0]  key_word = '0;
    logic         rnd_gnt, rnd_vld, key_gnt, key_vld, busy;
    logic [127:0] rnd_res, sb_in, sb_out;
    logic [31:0]  key_res;
    int           cyc = 0, checks = 0, errors = 0;

    typedef struct { logic key; logic [127:0] data; int cyc; } exp_t;
    exp_t q[$];

    logic [2047:0] tab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [127:0] sub128(input logic [127:0] x);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = tab[2047 - 8*x[8*b +: 8] -: 8];
        return r;
    endfunction

    sbox_share_arb #(.SB_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rnd_req(rnd_req), .rnd_data(rnd_data), .rnd_gnt(rnd_gnt), .rnd_vld(rnd_vld), .rnd_res(rnd_res),
        .key_req(key_req), .key_word(key_word), .key_gnt(key_gnt), .key_vld(key_vld), .key_res(key_res),
        .flush(flush), .sb_in(sb_in), .sb_out(sb_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) sb_out <= sub128(sb_in);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rr, input logic [127:0] rd, input logic kr, input logic [31:0] kw,
                         input logic fl, input logic [127:0] er, input logic [31:0] ek,
                         output logic gr, output logic gk);
        @(negedge clk);
        rnd_req = rr; rnd_data = rd; key_req = kr; key_word = kw; flush = fl;
        #1;
        gr = rnd_gnt; gk = key_gnt;
        if (gr) q.push_back('{1'b0, er, cyc + 3});
        if (gk) q.push_back('{1'b1, {96'h0, ek}, cyc + 3});
    endtask

    task automatic idle(input int n);
        logic gr, gk;
        repeat (n) drive(0, '0, 0, '0, 0, '0, '0, gr, gk);
    endtask

    // monitor: every result pulse must match the oldest outstanding issue
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rnd_vld || key_vld) begin
            chk("one_vld", 128'(rnd_vld & key_vld), 128'(0));
            if (q.size() == 0) chk("unexpected_vld", 128'({rnd_vld, key_vld}), 128'(0));
            else begin
                e = q.pop_front();
                chk("owner", 128'(key_vld), 128'(e.key));
                chk("res", key_vld ? 128'(key_res) : rnd_res, e.data);
                chk("latency", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    initial begin
        logic gr, gk;
        #12;
        chk("rst_sb_in", sb_in, '0);
        chk("rst_outs", 128'({rnd_vld, key_vld, busy}), 128'(0));
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [127:0] er;
            logic [31:0]  ek;
            er = (i == 0) ? {16{8'h63}} : (i == 2) ? {16{8'h77}} : {16{8'hf2}};
            ek = (i == 1) ? 32'h7c7c7c7c : (i == 3) ? 32'h7b7b7b7b : 32'h6b6b6b6b;
            drive(1, {16{8'(i)}}, 1, {4{8'(i)}}, 0, er, ek, gr, gk);
            chk("alt_gnt", 128'({gr, gk}), (i % 2 == 0) ? 128'(2'b10) : 128'(2'b01));
        end
        idle(5);
        drive(1, 128'h00112233_44556677_8899aabb_ccddeeff, 0, '0, 0,
              128'h638293c3_1bfc33f5_c4eeacea_4bc12816, '0, gr, gk);
        chk("rnd_gnt", 128'({gr, gk}), 128'(2'b10));
        idle(1); chk("busy_t1", 128'(busy), 128'(1));
        idle(1); chk("busy_t2", 128'(busy), 128'(1));
        idle(1); chk("busy_t3", 128'(busy), 128'(0));
        idle(3);
        drive(0, '0, 1, 32'h09cf4f3c, 0, '0, 32'h018a84eb, gr, gk);
        chk("key_gnt", 128'({gr, gk}), 128'(2'b01));
        idle(5);
        drive(1, '0, 0, '0, 0, {16{8'h63}}, '0, gr, gk);
        chk("b2b_rnd", 128'({gr, gk}), 128'(2'b10));
        drive(0, '0, 1, 32'hffffffff, 0, '0, 32'h16161616, gr, gk);
        chk("b2b_key", 128'({gr, gk}), 128'(2'b01));
        idle(5);
        drive(1, {16{8'h11}}, 0, '0, 0, {16{8'h82}}, '0, gr, gk);
        drive(0, '0, 1, 32'h22222222, 0, '0, 32'h93939393, gr, gk);
        drive(1, {16{8'h33}}, 1, 32'h44444444, 1, '0, '0, gr, gk);
        chk("flush_gnt", 128'({gr, gk}), 128'(0));
        q.delete();
        idle(1); chk("flush_busy", 128'(busy), 128'(0));
        idle(5);
        drive(1, {16{8'h55}}, 0, '0, 0, {16{8'hfc}}, '0, gr, gk);
        @(negedge clk);
        rnd_req = 1'b0;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_regs", 128'({rnd_vld, key_vld, busy, key_res}), 128'(0));
        chk("mid_rst_res", rnd_res, '0);
        chk("mid_rst_sb_in", sb_in, '0);
        @(negedge clk) rst_n = 1'b1;
        idle(5);
        drive(1, {16{8'h66}}, 1, 32'h77777777, 0, {16{8'h33}}, 32'hf5f5f5f5, gr, gk);
        chk("rst_tie_gnt", 128'({gr, gk}), 128'(2'b10));
        drive(0, '0, 1, 32'h77777777, 0, '0, 32'hf5f5f5f5, gr, gk);
        for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
        idle(2);
        chk("drained", 128'(q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sbox_share_arb.md
# sbox_share_arb

Arbiter and sequencer that time-shares the single 16-lane SUB_BYTES S-box array between two requesters. The round datapath substitutes a full 128-bit state; key expansion substitutes one 32-bit word (SubWord). The block sits between both requesters and the S-box array. It drives the array input, tracks in-flight operations through the array's fixed pipeline latency, and returns each result to its owner with a one-cycle valid pulse.

## Interface
- SB_LAT, 1: cycles from a new `sb_in` value to the matching `sb_out` value. Legal range 1..4.

- clk  input  1  system clock, rising edge
- rst_n  input  1  reset; asynchronous and active-low
- rnd_req  input  1  round datapath requests a substitution; held until granted
- rnd_data  input  128  state to substitute; sampled in the grant cycle
- rnd_gnt  output  1  combinational grant to the round datapath
- rnd_vld  output  1  one-cycle pulse; `rnd_res` is valid
- rnd_res  output  128  substituted state
- key_req  input  1  key expansion requests a SubWord; held until granted
- key_word  input  32  word to substitute; sampled in the grant cycle
- key_gnt  output  1  combinational grant to key expansion
- key_vld  output  1  one-cycle pulse; `key_res` is valid
- key_res  output  32  substituted word
- flush  input  1  synchronous abort of all in-flight operations
- sb_in  output  128  registered drive to the S-box array input
- sb_out  input  128  S-box array output
- busy  output  1  at least one operation is in flight

## Operation
- Issue:
  - An issue occurs in any cycle where (`rnd_req` & `rnd_gnt`) or (`key_req` & `key_gnt`).
  - At most one issue per cycle; `rnd_gnt` and `key_gnt` are never high together.
- Arbitration:
  - A 1-bit `last` pointer records the owner of the most recent issue.
  - Exactly one requester asserting: that requester is granted.
  - Both asserting: grant the requester other than `last`.
  - Reset value of `last` is key, so the round datapath wins the first tie.
  - `last` updates only on an actual issue.
- Grants:
  - Grants are forced low while `flush` = 1.
  - Grants do not depend on `busy`. The path is fully pipelined, so back-to-back issues are allowed every cycle.
- Drive:
  - Round issue: `sb_in` <= `rnd_data`.
  - Key issue: `sb_in` <= {96'h0, `key_word`}.
  - No issue: `sb_in` holds its value, to minimise toggling.
- Tag pipeline:
  - A shift register of depth SB_LAT+1.
  - Each entry is {valid, owner}. Entry 0 is loaded on issue.
  - The tag exits in the cycle `sb_out` carries the matching result.
- Return:
  - When an exiting tag is valid, register `sb_out` into `rnd_res`, or `sb_out[31:0]` into `key_res`, according to owner.
  - Pulse the matching `*_vld` for exactly one cycle.
  - The non-matching `*_res` holds its value.
  - Requesters cannot stall results; they must accept every pulse.
- Flush:
  - Clears every tag valid bit on the next edge. No result is delivered for any operation in flight at the flush edge.
  - Preserves `last`, `sb_in` and both `*_res` registers.
- `busy` is the OR of all tag valid bits. It is combinational from the tag registers.

## Timing
- Reset values: `sb_in` = 0, `rnd_res` = 0, `key_res` = 0, `rnd_vld` = 0, `key_vld` = 0, all tags invalid, `busy` = 0, `last` = key.
- Grants during reset follow the arbitration rule. No issue is recorded while `rst_n` = 0.
- Latency, issue cycle T:
  - `sb_in` is updated at T+1.
  - `sb_out` is valid at T+1+SB_LAT.
  - `*_vld` and `*_res` are visible at T+2+SB_LAT.
  - Worked case: SB_LAT = 1 gives `*_vld` at T+3.
- Throughput is one issue per cycle. Results return in issue order, one per cycle at most.
- `rnd_data` and `key_word` are sampled only at the grant edge and may change afterwards.
- Simultaneous events:
  - `flush` together with an exiting tag: the result is suppressed.
  - `flush` together with requests: no grant and no issue that cycle.
- Asynchronous reset mid-operation drops all in-flight operations immediately. There is no partial delivery.

## Test plan
- Single round issue, SB_LAT = 1: `rnd_data` = 128'h00112233_44556677_8899aabb_ccddeeff granted at T. Require `rnd_vld` at T+3 with `rnd_res` = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816, and `busy` high for T+1..T+2.
- Single key issue: `key_word` = 32'h09cf4f3c. Require `key_vld` three cycles later with `key_res` = 32'h018a84eb, and `rnd_vld` staying 0.
- Both requesters held high for 6 cycles from reset. Require grants to alternate rnd, key, rnd, key, rnd, key, and 6 result pulses in the same order on consecutive cycles.
- Back-to-back: rnd issues at T and key issues at T+1. Require `rnd_vld` at T+3 and `key_vld` at T+4, each with the correct data.
- Flush: two issues at T and T+1, `flush` = 1 at T+2. Require no `*_vld` pulses, `busy` = 0 from T+3, and both grants low at T+2.
- Reset mid-flight: assert `rst_n` = 0 one cycle after an issue. Require all outputs to reach reset values immediately and no `*_vld` after release.
